ctr_gain_scheduler: RTL and testbench

CTR_GAIN_SCHEDULER -- requirements
Module: ctr_gain_scheduler

---
 rtl/ctr_gain_scheduler.sv | 155 +++++++++++++++
 tb/tb_ctr_gain_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ctr_gain_scheduler.sv
// ctr_gain_scheduler: button-driven gain control for a wave and a noise channel, with seven-segment readout
// Ports:
//   i_clk, i_rst_n (async active-low), i_en (global enable)
//   i_btn_mode / i_btn_dir / i_btn_adj : raw active-low buttons (toggle target, toggle direction, step gain)
//   o_gain_wave, o_gain_noise : signed saturating gains, NUM_GAIN_STEP+1 bits
//   o_sel_noise (0 wave, 1 noise), o_dir_down (0 +1, 1 -1)
//   o_hex_mode / o_hex_sign / o_hex_val : registered active-low segments {g,f,e,d,c,b,a}
// Build option: define CTR_GAIN_AUTO_REPEAT_EN to enable hold-to-repeat on the adjust button.
module ctr_gain_scheduler #(
  parameter int NUM_GAIN_STEP = 3,
  parameter int NUM_SEG       = 7,
  parameter int HOLD_CYC      = 25_000_000,
  parameter int RPT_CYC       = 5_000_000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_btn_mode,
  input  logic                       i_btn_dir,
  input  logic                       i_btn_adj,
  output logic signed [NUM_GAIN_STEP:0] o_gain_wave,
  output logic signed [NUM_GAIN_STEP:0] o_gain_noise,
  output logic                       o_sel_noise,
  output logic                       o_dir_down,
  output logic [NUM_SEG-1:0]         o_hex_mode,
  output logic [NUM_SEG-1:0]         o_hex_sign,
  output logic [NUM_SEG-1:0]         o_hex_val
);
  localparam int GW = NUM_GAIN_STEP + 1;
  localparam logic signed [GW-1:0] ONE  = GW'(1);
  localparam logic signed [GW-1:0] MAXG = {1'b0, {NUM_GAIN_STEP{1'b1}}};
  localparam logic signed [GW-1:0] MING = {1'b1, {NUM_GAIN_STEP{1'b0}}};
  // bit 0 mode, bit 1 dir, bit 2 adj
  logic [2:0] s1, s2, s3, armed, prs_q;
  logic [1:0] vld;
  logic       step;
  logic signed [GW-1:0] tgt, nxt;
  logic [GW-1:0] mag;
  // Synchronizers reset to "released"; a button already held through reset would
  // look like a fresh 1->0 edge, so a button is only armed once it has been seen
  // released after the synchronizer has refilled with real samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1    <= '1;
      s2    <= '1;
      s3    <= '1;
      vld   <= '0;
      armed <= '0;
      prs_q <= '0;
    end else begin
      s1    <= {i_btn_adj, i_btn_dir, i_btn_mode};
      s2    <= s1;
      s3    <= s2;
      vld   <= {vld[0], 1'b1};
      armed <= armed | ({3{vld[1]}} & s2);
      prs_q <= {3{i_en}} & armed & s3 & ~s2;
    end
  end
`ifdef CTR_GAIN_AUTO_REPEAT_EN
  localparam int MAXC = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, lim;
  logic held;
  assign held = ~s2[2];
  assign lim  = (state == HOLD) ? CW'(HOLD_CYC - 1) : CW'(RPT_CYC - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    step     = 1'b0;
    if (!i_en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (state == IDLE) begin
      if (prs_q[2]) begin
        step     = 1'b1;
        cnt_nx   = '0;
        state_nx = prs_q[0] ? IDLE : HOLD;
      end
    end else if (!held || prs_q[0]) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (cnt == lim) begin
      step     = 1'b1;
      cnt_nx   = '0;
      state_nx = REPEAT;
    end else begin
      cnt_nx = cnt + 1'b1;
    end
  end
`else
  assign step = prs_q[2] & i_en;
`endif
  assign tgt = o_sel_noise ? o_gain_noise : o_gain_wave;
  assign nxt = o_dir_down ? ((tgt == MING) ? tgt : tgt - ONE)
                          : ((tgt == MAXG) ? tgt : tgt + ONE);
  // -MING wraps to the same bit pattern, which reads correctly as unsigned magnitude
  assign mag = tgt[GW-1] ? $unsigned(-tgt) : $unsigned(tgt);
  // Steps use the pre-toggle target and direction; toggles land on the same edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gain_wave  <= ONE;
      o_gain_noise <= '0;
      o_sel_noise  <= 1'b0;
      o_dir_down   <= 1'b0;
    end else if (i_en) begin
      if (step && !o_sel_noise) o_gain_wave <= nxt;
      if (step && o_sel_noise) o_gain_noise <= nxt;
      if (prs_q[0]) o_sel_noise <= ~o_sel_noise;
      if (prs_q[1]) o_dir_down <= ~o_dir_down;
    end
  end
  function automatic logic [6:0] hex_seg(input int v);
    case (v)
      0:       hex_seg = 7'h40;
      1:       hex_seg = 7'h79;
      2:       hex_seg = 7'h24;
      3:       hex_seg = 7'h30;
      4:       hex_seg = 7'h19;
      5:       hex_seg = 7'h12;
      6:       hex_seg = 7'h02;
      7:       hex_seg = 7'h78;
      8:       hex_seg = 7'h00;
      9:       hex_seg = 7'h10;
      10:      hex_seg = 7'h08;
      11:      hex_seg = 7'h03;
      12:      hex_seg = 7'h46;
      13:      hex_seg = 7'h21;
      14:      hex_seg = 7'h06;
      15:      hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  endfunction
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hex_mode <= '1;
      o_hex_sign <= '1;
      o_hex_val  <= '1;
    end else begin
      o_hex_mode <= NUM_SEG'(o_sel_noise ? 7'h2B : 7'h08);
      o_hex_sign <= NUM_SEG'(tgt[GW-1] ? 7'h3F : 7'h7F);
      o_hex_val  <= NUM_SEG'(hex_seg(int'(mag)));
    end
  end
endmodule

// File: tb/tb_ctr_gain_scheduler.sv
// tb_ctr_gain_scheduler: scoreboard bench for ctr_gain_scheduler (auto-repeat expectations follow CTR_GAIN_AUTO_REPEAT_EN)
module tb_ctr_gain_scheduler;
`ifdef CTR_GAIN_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b1, bm = 1'b1, bd = 1'b1, ba = 1'b1;
  logic signed [3:0] gw, gn;
  logic sel, dn;
  logic [6:0] hm, hs, hv;
  int n_tests = 0, n_fail = 0;
  int mw = 1, mn = 0, ms = 0, md = 0;
  typedef struct {int w; int n; int s; int d;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ctr_gain_scheduler #(.NUM_GAIN_STEP(3), .NUM_SEG(7), .HOLD_CYC(10), .RPT_CYC(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_btn_mode(bm), .i_btn_dir(bd), .i_btn_adj(ba),
    .o_gain_wave(gw), .o_gain_noise(gn), .o_sel_noise(sel), .o_dir_down(dn),
    .o_hex_mode(hm), .o_hex_sign(hs), .o_hex_val(hv)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int stp(input int g, input int d);
    if (d != 0) return (g > -8) ? g - 1 : g;
    return (g < 7) ? g + 1 : g;
  endfunction

  function automatic int digit(input int m);
    case (m)
      0: return 'h40; 1: return 'h79; 2: return 'h24; 3: return 'h30; 4: return 'h19;
      5: return 'h12; 6: return 'h02; 7: return 'h78; 8: return 'h00;
      default: return 'h7F;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push();
    exp_t e;
    e.w = mw; e.n = mn; e.s = ms; e.d = md;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    int t;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    t = (e.s != 0) ? e.n : e.w;
    chk({tag, "_wave"}, int'(gw), e.w);
    chk({tag, "_noise"}, int'(gn), e.n);
    chk({tag, "_sel"}, int'(sel), e.s);
    chk({tag, "_dir"}, int'(dn), e.d);
    chk({tag, "_hmode"}, int'(hm), (e.s != 0) ? 'h2B : 'h08);
    chk({tag, "_hsign"}, int'(hs), (t < 0) ? 'h3F : 'h7F);
    chk({tag, "_hval"}, int'(hv), digit((t < 0) ? -t : t));
  endtask

  // which: bit0 mode, bit1 dir, bit2 adj
  task automatic tap(input int which, input string tag);
    @(negedge clk);
    bm = ~which[0]; bd = ~which[1]; ba = ~which[2];
    if (en) begin
      if (which[2]) begin
        if (ms != 0) mn = stp(mn, md);
        else mw = stp(mw, md);
      end
      if (which[0]) ms = 1 - ms;
      if (which[1]) md = 1 - md;
    end
    push();
    cyc(4);
    bm = 1'b1; bd = 1'b1; ba = 1'b1;
    cyc(6);
    pop_check(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mw = 1; mn = 0; ms = 0; md = 0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wave", int'(gw), 1);
    chk("rst_noise", int'(gn), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_dir", int'(dn), 0);
    chk("rst_hmode", int'(hm), 'h7F);
    chk("rst_hsign", int'(hs), 'h7F);
    chk("rst_hval", int'(hv), 'h7F);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    push();
    pop_check("post_rst");
    // exact adjust latency: first low sample at edge0, gain changes at edge3
    @(negedge clk);
    ba = 1'b0;
    mw = 2;
    cyc(1); chk("lat_e0", int'(gw), 1);
    cyc(1); chk("lat_e1", int'(gw), 1);
    cyc(1); chk("lat_e2", int'(gw), 1);
    cyc(1); chk("lat_e3", int'(gw), 2);
    chk("lat_hex_e3", int'(hv), 'h79);
    cyc(1); chk("lat_hex_e4", int'(hv), 'h24);
    ba = 1'b1;
    cyc(6);
    push();
    pop_check("lat_done");
    tap(1, "mode_noise");
    tap(1, "mode_wave");
    for (int i = 0; i < 10; i++) tap(4, "sat_up");
    chk("sat_max", int'(gw), 7);
    tap(2, "dir_down");
    for (int i = 0; i < 20; i++) tap(4, "sat_dn");
    chk("sat_min", int'(gw), -8);
    chk("sat_min_sign", int'(hs), 'h3F);
    chk("sat_min_val", int'(hv), 'h00);
    do_reset();
    tap(5, "coinc");
    chk("coinc_wave", int'(gw), 2);
    chk("coinc_noise", int'(gn), 0);
    chk("coinc_sel", int'(sel), 1);
    // hold adj on noise for 30 samples: steps at edge3, 13, 17, 21, 25, 29 with auto-repeat
    @(negedge clk);
    ba = 1'b0;
    cyc(13); chk("ar_e12", int'(gn), 1);
    cyc(1);  chk("ar_e13", int'(gn), AR ? 2 : 1);
    cyc(4);  chk("ar_e17", int'(gn), AR ? 3 : 1);
    cyc(12);
    ba = 1'b1;
    cyc(8);
    mn = AR ? 6 : 1;
    push();
    pop_check("ar_done");
    tap(2, "dir_down2");
    // disable during repeat: only steps at edge3, 13, 17 land
    @(negedge clk);
    ba = 1'b0;
    cyc(19);
    en = 1'b0;
    mn = AR ? mn - 3 : mn - 1;
    cyc(10);
    chk("en_freeze", int'(gn), mn);
    tap(1, "en_mode_lost");
    cyc(10);
    chk("en_freeze2", int'(gn), mn);
    ba = 1'b1;
    cyc(4);
    en = 1'b1;
    cyc(6);
    push();
    pop_check("en_resume");
    // reset while adj is held
    @(negedge clk);
    ba = 1'b0;
    cyc(20);
    rst_n = 1'b0;
    mw = 1; mn = 0; ms = 0; md = 0;
    #1;
    chk("rmid_wave", int'(gw), 1);
    chk("rmid_noise", int'(gn), 0);
    chk("rmid_hval", int'(hv), 'h7F);
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    push();
    pop_check("rmid_held");
    ba = 1'b1;
    cyc(5);
    tap(4, "rmid_repress");
    chk("rmid_repress_wave", int'(gw), 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
